// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//
// Shares a single-port 256x8 command-driven RAM between two requesters.
// Each accepted read or write is turned into a short sequence of 10-bit RAM
// commands: 00 = set write addr, 01 = write data, 10 = set read addr,
// 11 = read. The result is returned to the requesting port as a one-cycle
// response pulse. A read that gets no data back within TIMEOUT wait cycles
// completes with rdata = 8'hFF and an error flag.
//
// Parameters:
//   TIMEOUT        cycles allowed in RD_WAIT without ram_tx_valid (>= 1)
//   FIXED_PRIORITY 0 = round-robin between ports, 1 = port 0 wins every tie
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqN_valid/ready               request handshake for port N (0/1)
//   reqN_wr/addr/wdata             request type, RAM address, write data
//   rsp0_valid, rsp1_valid         one-cycle response pulse per port
//   rsp_rdata, rsp_err             response payload, held until next response
//   ram_din, ram_rx_valid          command word and strobe to the RAM
//   ram_dout, ram_tx_valid         read data and its valid from the RAM
//   busy                           high whenever a transaction is in flight
module ram_access_arbiter #(
    parameter int TIMEOUT        = 4,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_wr,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_wdata,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_wr,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,
    output logic       busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_CMD  = 3'd4,
        RD_WAIT = 3'd5
    } state_t;

    state_t        state_q;
    logic          last_grant_q;
    logic          id_q;
    logic          wr_q;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic [CW-1:0] cnt_q;
    logic          rsp0_valid_q;
    logic          rsp1_valid_q;
    logic [7:0]    rsp_rdata_q;
    logic          rsp_err_q;

    // Winner of the current arbitration round and its request fields.
    logic       grant_any_d;
    logic       grant_id_d;
    logic       req_wr_d;
    logic [7:0] req_addr_d;
    logic [7:0] req_wdata_d;

    always_comb begin
        grant_any_d = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            // Round-robin: the port that did not win last time goes next.
            grant_id_d = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
        end else begin
            grant_id_d = req1_valid;
        end
        req_wr_d    = grant_id_d ? req1_wr    : req0_wr;
        req_addr_d  = grant_id_d ? req1_addr  : req0_addr;
        req_wdata_d = grant_id_d ? req1_wdata : req0_wdata;
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant_id_d;
    assign req1_ready = (state_q == IDLE) && req1_valid &&  grant_id_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            cnt_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_rdata_q  <= 8'h00;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any_d) begin
                        id_q         <= grant_id_d;
                        wr_q         <= req_wr_d;
                        addr_q       <= req_addr_d;
                        wdata_q      <= req_wdata_d;
                        last_grant_q <= grant_id_d;
                        state_q      <= req_wr_d ? WR_ADDR : RD_ADDR;
                    end
                end
                WR_ADDR: state_q <= WR_DATA;
                WR_DATA: begin
                    rsp0_valid_q <= ~id_q;
                    rsp1_valid_q <= id_q;
                    rsp_rdata_q  <= 8'h00;
                    rsp_err_q    <= 1'b0;
                    state_q      <= IDLE;
                end
                RD_ADDR: state_q <= RD_CMD;
                RD_CMD: begin
                    cnt_q   <= '0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Data arriving on the expiry cycle still counts as a hit.
                    if (ram_tx_valid) begin
                        rsp0_valid_q <= ~id_q;
                        rsp1_valid_q <= id_q;
                        rsp_rdata_q  <= ram_dout;
                        rsp_err_q    <= 1'b0;
                        state_q      <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp0_valid_q <= ~id_q;
                        rsp1_valid_q <= id_q;
                        rsp_rdata_q  <= 8'hFF;
                        rsp_err_q    <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM command word is decoded straight from the state register, so it
    // follows the state (and an asynchronous reset) without extra delay.
    always_comb begin
        ram_din      = 10'h000;
        ram_rx_valid = 1'b0;
        case (state_q)
            WR_ADDR: begin
                ram_din      = {2'b00, addr_q};
                ram_rx_valid = 1'b1;
            end
            WR_DATA: begin
                ram_din      = {2'b01, wdata_q};
                ram_rx_valid = 1'b1;
            end
            RD_ADDR: begin
                ram_din      = {2'b10, addr_q};
                ram_rx_valid = 1'b1;
            end
            RD_CMD: begin
                ram_din      = {2'b11, 8'h00};
                ram_rx_valid = 1'b1;
            end
            default: begin
                ram_din      = 10'h000;
                ram_rx_valid = 1'b0;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;

    // wr_q is kept for visibility of the accepted request; the state encodes it.
    logic unused_wr;
    assign unused_wr = wr_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Testbench for ram_access_arbiter: a behavioural command-driven RAM model,
// a table of directed transactions, and hand-written sequences for timeout,
// stray RAM strobes, asynchronous reset and arbitration order.
module tb_ram_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0_valid, req0_ready, req0_wr;
    logic [7:0] req0_addr, req0_wdata;
    logic       req1_valid, req1_ready, req1_wr;
    logic [7:0] req1_addr, req1_wdata;
    logic       rsp0_valid, rsp1_valid, rsp_err, busy;
    logic [7:0] rsp_rdata;
    logic [9:0] ram_din;
    logic       ram_rx_valid, ram_tx_valid;
    logic [7:0] ram_dout;

    logic       fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
    logic       fp_rsp_err, fp_ram_rx_valid, fp_busy;
    logic [7:0] fp_rsp_rdata;
    logic [9:0] fp_ram_din;

    int n_checks = 0;
    int n_fail   = 0;

    ram_access_arbiter #(.TIMEOUT(4), .FIXED_PRIORITY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(busy)
    );

    // Fixed-priority instance sharing the same stimulus; it runs in lockstep
    // because every transaction has the same length in both instances.
    ram_access_arbiter #(.TIMEOUT(4), .FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_wr(req0_wr),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_wr(req1_wr),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(fp_rsp0_valid), .rsp1_valid(fp_rsp1_valid),
        .rsp_rdata(fp_rsp_rdata), .rsp_err(fp_rsp_err),
        .ram_din(fp_ram_din), .ram_rx_valid(fp_ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(fp_busy)
    );

    // Behavioural RAM: read data appears one cycle after the read command.
    logic [7:0] mem [256];
    logic [7:0] wa = 8'h00, ra = 8'h00, model_dout = 8'h00;
    logic       model_tx = 1'b0;
    logic       ram_mute = 1'b0;
    logic       stray_tx = 1'b0;
    logic [7:0] stray_dout = 8'h00;

    always @(posedge clk) begin
        model_tx <= 1'b0;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: wa <= ram_din[7:0];
                2'b01: mem[wa] <= ram_din[7:0];
                2'b10: ra <= ram_din[7:0];
                default: begin
                    if (!ram_mute) begin
                        model_tx   <= 1'b1;
                        model_dout <= mem[ra];
                    end
                end
            endcase
        end
    end

    assign ram_tx_valid = model_tx | stray_tx;
    assign ram_dout     = stray_tx ? stray_dout : model_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge
    // of the first cycle after the handshake.
    task automatic start_req(input bit port, input bit wr, input logic [7:0] addr,
                             input logic [7:0] wdata);
        if (port == 1'b0) begin
            req0_valid = 1'b1; req0_wr = wr; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = 1'b1; req1_wr = wr; req1_addr = addr; req1_wdata = wdata;
        end
        #1;
        check("ready_winner", port ? req1_ready : req0_ready, 1);
        check("ready_other",  port ? req0_ready : req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rsp_single_pulse", {30'd0, rsp1_valid, rsp0_valid}, 0);
        check("busy_after_hs", busy, 1);
    endtask

    // Follows a transaction from cycle 1 to its response; returns at the
    // falling edge of the response cycle.
    task automatic wait_rsp(input bit port, input bit wr, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] exp_rdata,
                            input bit exp_err, input int exp_lat);
        int lat = 1;
        int ncmd = 0;
        int waits = 0;
        logic [9:0] cmds [4];
        bit got = 1'b0;
        bit other = 1'b0;
        for (int k = 0; k < 4; k++) cmds[k] = 10'h000;
        while (!got && lat <= 20) begin
            if (ram_rx_valid) begin
                if (ncmd < 4) cmds[ncmd] = ram_din;
                ncmd++;
            end else if (busy) begin
                waits++;
            end
            if (port ? rsp0_valid : rsp1_valid) other = 1'b1;
            if (port ? rsp1_valid : rsp0_valid) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check("rsp_seen", got, 1);
        check("rsp_other_port", other, 0);
        check("latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_err);
        check("wait_cycles", waits, exp_lat - 3);
        check("cmd_count", ncmd, 2);
        check("cmd0", cmds[0], wr ? {2'b00, addr} : {2'b10, addr});
        check("cmd1", cmds[1], wr ? {2'b01, wdata} : {2'b11, 8'h00});
        $display("txn port=%0d %s addr=%02h wdata=%02h -> lat=%0d rdata=%02h err=%0d",
                 port, wr ? "WR" : "RD", addr, wdata, lat, rsp_rdata, rsp_err);
    endtask

    typedef struct {
        bit         port;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         err;
        int         lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  ng;
        bit  seen;
        bit  exp_port;

        vecs[0] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0, 3};
        vecs[1] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 4};
        vecs[2] = '{1'b1, 1'b1, 8'h7F, 8'h5A, 8'h00, 1'b0, 3};
        vecs[3] = '{1'b0, 1'b0, 8'h7F, 8'h00, 8'h5A, 1'b0, 4};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 1'b0, 3};
        vecs[5] = '{1'b1, 1'b1, 8'hFF, 8'h80, 8'h00, 1'b0, 3};
        vecs[6] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h80, 1'b0, 4};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 4};

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_wr = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
        req1_valid = 1'b0; req1_wr = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_ram_din", ram_din, 10'h000);
        check("rst_ram_rx_valid", ram_rx_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: consecutive transactions, each handshake lands in the
        // previous response cycle (back-to-back).
        for (int i = 0; i < 8; i++) begin
            start_req(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            wait_rsp(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                     vecs[i].rdata, vecs[i].err, vecs[i].lat);
        end

        // Stray ram_tx_valid while idle
        @(negedge clk);
        stray_tx = 1'b1; stray_dout = 8'h55;
        @(negedge clk);
        stray_tx = 1'b0;
        check("stray_idle_rsp", {30'd0, rsp1_valid, rsp0_valid}, 0);
        check("stray_idle_busy", busy, 0);
        check("stray_idle_rdata_hold", rsp_rdata, 8'h01);
        @(negedge clk);
        check("stray_idle_rsp_late", {30'd0, rsp1_valid, rsp0_valid}, 0);
        $display("txn stray tx_valid in IDLE -> rsp=%0d%0d busy=%0d", rsp1_valid, rsp0_valid, busy);

        // Stray ram_tx_valid during WR_DATA
        start_req(1'b0, 1'b1, 8'h10, 8'h66);
        @(negedge clk);
        check("wrdata_cmd", ram_din, 10'h166);
        stray_tx = 1'b1; stray_dout = 8'h99;
        @(negedge clk);
        stray_tx = 1'b0;
        check("stray_wr_rsp0", rsp0_valid, 1);
        check("stray_wr_rdata", rsp_rdata, 8'h00);
        check("stray_wr_err", rsp_err, 0);
        check("stray_wr_busy", busy, 0);
        @(negedge clk);
        check("stray_wr_pulse_end", rsp0_valid, 0);
        $display("txn port=0 WR addr=10 with stray tx_valid -> rdata=%02h err=%0d", rsp_rdata, rsp_err);

        // Timeout: RAM never answers
        ram_mute = 1'b1;
        start_req(1'b1, 1'b0, 8'h3C, 8'h00);
        wait_rsp(1'b1, 1'b0, 8'h3C, 8'h00, 8'hFF, 1'b1, 7);
        @(negedge clk);
        check("timeout_pulse_end", rsp1_valid, 0);
        check("timeout_err_hold", rsp_err, 1);
        check("timeout_rdata_hold", rsp_rdata, 8'hFF);

        // Data on the expiry cycle wins over the error
        start_req(1'b0, 1'b0, 8'h20, 8'h00);
        repeat (5) @(negedge clk);
        check("expiry_busy", busy, 1);
        check("expiry_no_rsp", rsp0_valid, 0);
        stray_tx = 1'b1; stray_dout = 8'h77;
        @(negedge clk);
        stray_tx = 1'b0;
        check("expiry_rsp0", rsp0_valid, 1);
        check("expiry_rdata", rsp_rdata, 8'h77);
        check("expiry_err", rsp_err, 0);
        $display("txn port=0 RD addr=20 tx_valid on expiry -> rdata=%02h err=%0d", rsp_rdata, rsp_err);
        ram_mute = 1'b0;

        // Asynchronous reset in RD_CMD
        @(negedge clk);
        start_req(1'b1, 1'b0, 8'h3C, 8'h00);
        @(negedge clk);
        check("rdcmd_cmd", ram_din, 10'h300);
        check("rdcmd_rx_valid", ram_rx_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ram_din", ram_din, 10'h000);
        check("arst_rx_valid", ram_rx_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_rsp_rdata", rsp_rdata, 8'h00);
        check("arst_rsp_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
        end
        check("arst_no_rsp", seen, 0);
        $display("txn reset in RD_CMD -> aborted, activity_after=%0d", seen);

        // Arbitration: both ports request writes continuously
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 8'h40; req0_wdata = 8'h11;
        req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 8'h41; req1_wdata = 8'h22;
        ng = 0;
        exp_port = 1'b0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            #1;
            if (!busy) begin
                check("rr_grant", {30'd0, req1_ready, req0_ready}, exp_port ? 2 : 1);
                check("fp_grant", {30'd0, fp_req1_ready, fp_req0_ready}, 1);
                $display("txn tie round %0d: rr grant=%0d%0d fp grant=%0d%0d", ng,
                         req1_ready, req0_ready, fp_req1_ready, fp_req0_ready);
                exp_port = ~exp_port;
                ng++;
            end
            @(negedge clk);
        end
        check("rr_grant_count", ng, 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("final_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
